// File: rtl/slave_ram_ws.sv
// Word-addressed 32-bit RAM target with programmable wait states on a req/ack handshake.
// Optional random wait states when SLAVE_RAND_WAIT_EN is defined (LFSR-driven).
module slave_ram_ws #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WAIT_CYC = 2,
    parameter int unsigned WAIT_MAX = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cmd,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata_tr,
    output logic [15:0] txn_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                cmd_q, cmd_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [15:0]         txn_q, txn_d;
    logic                mem_we;
    logic [3:0]          wait_ld;
    logic [31:0]         mem [Depth];

    // Only the low ADDR_W address bits select a word; the rest alias.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W];

`ifdef SLAVE_RAND_WAIT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign wait_ld = 4'(32'(lfsr_q) % (WAIT_MAX + 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    logic unused_param;
    assign unused_param = (WAIT_CYC != 0);
`else
    assign wait_ld = 4'(WAIT_CYC);

    logic unused_param;
    assign unused_param = (WAIT_MAX != 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        txn_d   = txn_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = addr[ADDR_W-1:0];
                    cmd_d   = cmd;
                    wdata_d = wdata;
                    cnt_d   = wait_ld;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Completion side effects all land on the edge that raises ack.
                if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    txn_d   = txn_q + 16'd1;
                    if (cmd_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                // req is deliberately ignored here: the master still shows the finished transfer.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            txn_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            txn_q   <= txn_d;
        end
    end

    // RAM has no reset; a reset edge still blocks the pending write.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign ack      = (state_q == StAck);
    assign rdata_tr = rdata_q;
    assign txn_cnt  = txn_q;

endmodule

// File: tb/tb_slave_ram_ws.sv
// Scoreboard bench for slave_ram_ws: reset, write/read, aliasing, held-req stream, reset mid-wait.
// Define SLAVE_RAND_WAIT_EN for both bench and RTL to exercise random wait states.
module tb_slave_ram_ws;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned WAIT_CYC = 2;
    localparam int unsigned WAIT_MAX = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata_tr;
    logic [15:0] txn_cnt;

    slave_ram_ws #(
        .ADDR_W  (ADDR_W),
        .WAIT_CYC(WAIT_CYC),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .addr    (addr),
        .cmd     (cmd),
        .wdata   (wdata),
        .ack     (ack),
        .rdata_tr(rdata_tr),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rdata;
        logic [15:0] txn;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [256];
    logic [31:0] exp_rdata;
    logic [15:0] exp_txn;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_cnt = 0;
    logic        ack_prev = 1'b0;
    logic [15:0] lat_seen = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Scoreboard consumer: every ack pops one expected transfer.
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            ack_cnt++;
            check("ack_1cyc", {31'b0, ack_prev}, 32'd0);
            if (sb_q.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check(e.rd ? "rdata" : "rdata_hold", rdata_tr, e.rdata);
                check("txn_cnt", {16'h0, txn_cnt}, {16'h0, e.txn});
            end
        end
        ack_prev = ack;
    end

    task automatic xfer(input logic c, input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t e;
        int   lat;
        bit   got;
        @(posedge clk);
        #1;
        req   = 1'b1;
        cmd   = c;
        addr  = a;
        wdata = d;
        exp_txn++;
        if (c) mem_m[a[7:0]] = d;
        else   exp_rdata = mem_m[a[7:0]];
        e.rd    = !c;
        e.rdata = exp_rdata;
        e.txn   = exp_txn;
        sb_q.push_back(e);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end else begin
`ifdef SLAVE_RAND_WAIT_EN
            check("lat_range", {31'b0, (lat >= 3 && lat <= int'(WAIT_MAX) + 3)}, 32'd1);
            if (lat < 16) lat_seen[lat] = 1'b1;
`else
            check("latency", 32'(lat), WAIT_CYC + 3);
`endif
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            req = 1'b0;
        end
    endtask

    initial begin
        int a0;
        reset = 1'b0;
        req   = 1'b1;
        cmd   = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        exp_rdata = 32'h0;
        exp_txn   = 16'h0;

        repeat (3) begin
            @(negedge clk);
            check("rst_ack", {31'b0, ack}, 32'd0);
            check("rst_rdata", rdata_tr, 32'd0);
            check("rst_txn", {16'h0, txn_cnt}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 1'b0;

        xfer(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
        xfer(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        check("wr_rd_data", rdata_tr, 32'h1111_1111);
        check("wr_rd_txn", {16'h0, txn_cnt}, 32'd2);

        xfer(1'b1, 32'h0000_0105, 32'h2222_2222, 1'b0);
        xfer(1'b0, 32'h8000_0005, 32'h0, 1'b0);
        check("alias_data", rdata_tr, 32'h2222_2222);

        // req never drops between transfers.
        a0 = ack_cnt;
        for (int i = 0; i < 8; i++) begin
            xfer(i[0] ? 1'b0 : 1'b1, 32'h30 + 32'(i / 2), $urandom, i != 7);
        end
        check("stream_acks", 32'(ack_cnt - a0), 32'd8);

        xfer(1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 1'b0);
        @(posedge clk);
        #1;
        req   = 1'b1;
        cmd   = 1'b1;
        addr  = 32'h0000_0020;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 1'b0;
        exp_txn   = 16'h0;
        exp_rdata = 32'h0;
        a0 = ack_cnt;
        repeat (10) @(negedge clk);
        check("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("midrst_txn", {16'h0, txn_cnt}, 32'd0);
        check("midrst_rdata", rdata_tr, 32'd0);
        xfer(1'b0, 32'h0000_0020, 32'h0, 1'b0);
        check("midrst_prior", rdata_tr, 32'hA5A5_5A5A);
        check("midrst_txn1", {16'h0, txn_cnt}, 32'd1);

        for (int i = 0; i < 64; i++) begin
            xfer(i[0] ? 1'b0 : 1'b1, 32'h40 + 32'(i / 2), $urandom, bit'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (12) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("final_txn", {16'h0, txn_cnt}, {16'h0, exp_txn});
`ifdef SLAVE_RAND_WAIT_EN
        check("lat_distinct", {31'b0, ($countones(lat_seen) > 1)}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
